division_arbiter: RTL and testbench

//   Shares one sequential 32-bit restoring divider among NUM_REQ requesters.

---
 rtl/division_arbiter.sv | 130 +++++++++++++
 tb/tb_division_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/division_arbiter.sv
// Round-robin front end that shares one fixed-latency sequential divider among NUM_REQ requesters.
// Divide-by-zero requests are answered locally and never start the divider.
module division_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ),
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_q,
  output logic [31:0]           resp_r,
  output logic                  resp_dbz,
  output logic                  busy,
  output logic                  div_start,
  output logic [31:0]           div_a,
  output logic [31:0]           div_b,
  input  logic [31:0]           div_q,
  input  logic [31:0]           div_r
);

  localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       a_q, b_q;
  logic [ID_W-1:0]   id_q;
  logic [31:0]       hold_q, hold_r;
  logic [ID_W-1:0]   hold_id;
  logic              hold_dbz;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [31:0]       grant_a, grant_b;
  logic              accept;
  logic              grant_dbz;

  // Round-robin search: first valid index at or after ptr_q, wrapping.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[(int'(ptr_q) + i) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign grant_a   = req_a[32*grant_id +: 32];
  assign grant_b   = req_b[32*grant_id +: 32];
  assign grant_dbz = (grant_b == '0);
  assign accept    = (state_q == IDLE) && !reset && grant_found;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = grant_dbz ? DONE : START;
      START:   state_d = BUSY;
      BUSY:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      hold_q   <= '0;
      hold_r   <= '0;
      hold_id  <= '0;
      hold_dbz <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        a_q   <= grant_a;
        b_q   <= grant_b;
        id_q  <= grant_id;
        if (grant_dbz) begin
          hold_q   <= '1;
          hold_r   <= grant_a;
          hold_id  <= grant_id;
          hold_dbz <= 1'b1;
        end
      end
      if (state_q == START) cnt_q <= CNT_W'(DIV_CYCLES-1);
      if (state_q == BUSY) begin
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          hold_id  <= id_q;
          hold_dbz <= 1'b0;
        end
      end
      // Counter reaches 0 in DONE, the cycle in which the divider result is valid.
      if (state_q == DONE && !hold_dbz) begin
        hold_q <= div_q;
        hold_r <= div_r;
      end
    end
  end

  assign resp_valid = (state_q == DONE) && !reset;
  assign div_start  = (state_q == START) && !reset;
  assign busy       = (state_q != IDLE);
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign resp_id    = hold_id;
  assign resp_dbz   = hold_dbz;
  // During a divider DONE the result passes straight through, then is held.
  assign resp_q     = (state_q == DONE && !hold_dbz) ? div_q : hold_q;
  assign resp_r     = (state_q == DONE && !hold_dbz) ? div_r : hold_r;

endmodule

// File: tb/tb_division_arbiter.sv
// Directed bench for division_arbiter with a behavioural fixed-latency divider model.
module tb_division_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int DIV_CYCLES = 32;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_q, resp_r;
  logic                  resp_dbz, busy, div_start;
  logic [31:0]           div_a, div_b;
  logic [31:0]           div_q = '0;
  logic [31:0]           div_r = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  division_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_q(resp_q), .resp_r(resp_r),
    .resp_dbz(resp_dbz), .busy(busy),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r)
  );

  // Divider model: garbage until DIV_CYCLES cycles after the start cycle, then a/b and a%b.
  logic [31:0] m_a = '0, m_b = 32'd1;
  int          m_cnt = 0;
  always @(posedge clock) begin
    if (div_start) begin
      m_a   <= div_a;
      m_b   <= div_b;
      m_cnt <= DIV_CYCLES - 1;
      div_q <= 32'hDEAD_BEEF;
      div_r <= 32'hBAAD_F00D;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        div_q <= m_a / m_b;
        div_r <= m_a % m_b;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(negedge clock);
    #1;
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
    req_valid[k]       = 1'b1;
    req_a[32*k +: 32]  = a;
    req_b[32*k +: 32]  = b;
  endtask

  // Called in an IDLE cycle; expects requester k to be granted in this very cycle.
  task automatic serve(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    int lat;
    int starts;
    set_req(k, a, b);
    #1;
    check("grant", req_ready, 64'(1) << k);
    check("busy_c0", busy, 0);
    next_cycle();
    req_valid[k] = 1'b0;
    #1;
    check("busy_c1", busy, 1);
    check("div_start_c1", div_start, !edbz);
    check("div_a", div_a, a);
    check("div_b", div_b, b);
    starts = int'(div_start);
    lat    = 1;
    while (!resp_valid && lat < 4*DIV_CYCLES) begin
      next_cycle();
      #1;
      lat++;
      starts += int'(div_start);
    end
    check("latency", lat, edbz ? 1 : DIV_CYCLES + 1);
    check("resp_id", resp_id, k);
    check("resp_q", resp_q, eq);
    check("resp_r", resp_r, er);
    check("resp_dbz", resp_dbz, edbz);
    check("div_start_count", starts, edbz ? 0 : 1);
  endtask

  initial begin
    int stray;
    reset     = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;

    // 1. Reset held two cycles with requests pending.
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_div_start", div_start, 0);
      check("rst_resp_q", resp_q, 0);
      check("rst_resp_r", resp_r, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_dbz", resp_dbz, 0);
      check("rst_div_a", div_a, 0);
      check("rst_div_b", div_b, 0);
    end
    next_cycle();
    reset     = 1'b0;
    req_valid = '0;
    #1;
    check("idle_ready", req_ready, 0);

    // 2. Single request 100 / 7.
    next_cycle();
    serve(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    next_cycle();
    #1;
    check("hold_valid", resp_valid, 0);
    check("hold_busy", busy, 0);
    check("hold_q", resp_q, 14);
    check("hold_r", resp_r, 2);

    // 3. All four held from a fresh pointer, then 4'b1010.
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    set_req(0, 32'd100, 32'd7);
    set_req(1, 32'd50, 32'd5);
    set_req(2, 32'd77, 32'd10);
    set_req(3, 32'd1000, 32'd33);
    serve(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    next_cycle();
    serve(1, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    next_cycle();
    serve(2, 32'd77, 32'd10, 32'd7, 32'd7, 1'b0);
    next_cycle();
    serve(3, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0);
    next_cycle();
    set_req(3, 32'd1000, 32'd33);
    serve(1, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    next_cycle();
    serve(3, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0);

    // 4. Divide by zero answered locally.
    next_cycle();
    serve(2, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1);

    // 5. Reset in BUSY at cycle 10 aborts the transaction.
    next_cycle();
    set_req(1, 32'd9, 32'd3);
    #1;
    check("t5_grant", req_ready, 4'b0010);
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (c == 1) req_valid[1] = 1'b0;
    end
    #1;
    check("t5_busy_c10", busy, 1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    check("t5_busy_after", busy, 0);
    check("t5_div_start_after", div_start, 0);
    stray = 0;
    for (int c = 0; c < DIV_CYCLES + 8; c++) begin
      next_cycle();
      #1;
      if (resp_valid) stray++;
    end
    check("t5_no_resp", stray, 0);
    next_cycle();
    serve(1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // 6. Edge operands.
    next_cycle();
    serve(3, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    next_cycle();
    serve(0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
    next_cycle();
    serve(2, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
